// File: rtl/scarv_cop_malu_pkg.sv
// Shared definitions for the coprocessor multi-precision ALU.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package scarv_cop_malu_pkg;

   typedef enum logic [2:0] {
      MALU_OP_ADD   = 3'd0,
      MALU_OP_SUB   = 3'd1,
      MALU_OP_MUL   = 3'd2,
      MALU_OP_CLMUL = 3'd3,
      MALU_OP_MACC  = 3'd4,
      MALU_OP_SLL   = 3'd5,
      MALU_OP_SRL   = 3'd6,
      MALU_OP_RSV   = 3'd7
   } malu_op_t;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      MUL    = 2'd1,
      RSP_LO = 2'd2,
      RSP_HI = 2'd3
   } malu_state_t;

endpackage

// File: rtl/scarv_cop_mul_step.sv
// One digit step of the iterative multiplier: acc +/^= (rs1 x digit) << (cnt*MUL_STEP).
// Latency: combinational.
// Backpressure: none; the caller decides when to register acc_nxt.
module scarv_cop_mul_step #(
   parameter int XLEN     = 32,
   parameter int MUL_STEP = 4,
   parameter int CW       = 3
) (
   input  logic [XLEN-1:0]     rs1,
   input  logic [MUL_STEP-1:0] digit,
   input  logic [CW-1:0]       cnt,
   input  logic [2*XLEN-1:0]   acc,
   input  logic                clmul,
   output logic [2*XLEN-1:0]   acc_nxt
);

   localparam int AW = $clog2(2*XLEN);

   logic [2*XLEN-1:0] a_ext;
   logic [2*XLEN-1:0] pp_mul;
   logic [2*XLEN-1:0] pp_clm;
   logic [2*XLEN-1:0] pp;
   logic [AW-1:0]     sh;

   // Partial product for this digit (integer or carry-less), aligned and folded into acc.
   always_comb begin
      a_ext  = {{XLEN{1'b0}}, rs1};
      pp_mul = a_ext * {{(2*XLEN-MUL_STEP){1'b0}}, digit};
      pp_clm = '0;
      for (int i = 0; i < MUL_STEP; i++) begin
         if (digit[i]) pp_clm = pp_clm ^ (a_ext << i);
      end
      sh      = AW'(cnt) * AW'(MUL_STEP);
      pp      = (clmul ? pp_clm : pp_mul) << sh;
      acc_nxt = clmul ? (acc ^ pp) : (acc + pp);
   end

endmodule

// File: rtl/scarv_cop_malu_iter.sv
// Iterative multi-precision ALU: 2*XLEN-bit result returned as a low beat then a high beat.
// Latency: first beat 1 cycle after accept, or 1+XLEN/MUL_STEP cycles for MUL/CLMUL.
// Backpressure: beats hold stable until rsp_ready; no new request until the high beat is taken.
module scarv_cop_malu_iter
   import scarv_cop_malu_pkg::*;
#(
   parameter int XLEN     = 32,
   parameter int MUL_STEP = 4,
   parameter int SHW      = $clog2(2*XLEN)
) (
   input  logic            g_clk,
   input  logic            g_resetn,
   input  logic            flush,
   input  logic            req_valid,
   output logic            req_ready,
   input  logic [2:0]      req_op,
   input  logic [XLEN-1:0] req_rs1,
   input  logic [XLEN-1:0] req_rs2,
   input  logic [XLEN-1:0] req_rs3,
   output logic            rsp_valid,
   input  logic            rsp_ready,
   output logic            rsp_hi,
   output logic [XLEN-1:0] rsp_wdata
);

   localparam int N  = XLEN / MUL_STEP;
   localparam int CW = (N > 1) ? $clog2(N) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);

   malu_state_t       state;
   malu_state_t       state_nxt;
   malu_op_t          op_in;
   logic              accept;
   logic              is_iter;
   logic              is_clmul;

   logic [2*XLEN-1:0] res;
   logic [2*XLEN-1:0] sc_res;
   logic [2*XLEN-1:0] acc_nxt;
   logic [XLEN-1:0]   m_rs1;
   logic [XLEN-1:0]   m_rs2;
   logic              m_clmul;
   logic [CW-1:0]     cnt;

   logic [2*XLEN-1:0] x1;
   logic [2*XLEN-1:0] x2;
   logic [2*XLEN-1:0] cin;
   logic [2*XLEN-1:0] pair;
   logic [SHW-1:0]    shamt;
   logic              shift_ovf;

   // Single-cycle datapath; for MUL/CLMUL it produces the accumulator seed zext(rs3).
   always_comb begin
      op_in     = malu_op_t'(req_op);
      x1        = {{XLEN{1'b0}}, req_rs1};
      x2        = {{XLEN{1'b0}}, req_rs2};
      cin       = {{(2*XLEN-1){1'b0}}, req_rs3[0]};
      pair      = {req_rs2, req_rs1};
      shamt     = req_rs3[SHW-1:0];
      shift_ovf = |req_rs3[XLEN-1:SHW];
      is_clmul  = (op_in == MALU_OP_CLMUL);
      is_iter   = (op_in == MALU_OP_MUL) || is_clmul;
      sc_res    = '0;
      case (op_in)
         MALU_OP_ADD:   sc_res = x1 + x2 + cin;
         MALU_OP_SUB:   sc_res = x1 - x2 - cin;
         MALU_OP_MUL,
         MALU_OP_CLMUL: sc_res = {{XLEN{1'b0}}, req_rs3};
         MALU_OP_MACC:  sc_res = {req_rs2, req_rs3} + x1;
         MALU_OP_SLL:   sc_res = shift_ovf ? '0 : (pair << shamt);
         MALU_OP_SRL:   sc_res = shift_ovf ? '0 : (pair >> shamt);
         default:       sc_res = '0;
      endcase
   end

   scarv_cop_mul_step #(
      .XLEN     (XLEN),
      .MUL_STEP (MUL_STEP),
      .CW       (CW)
   ) u_step (
      .rs1     (m_rs1),
      .digit   (m_rs2[MUL_STEP-1:0]),
      .cnt     (cnt),
      .acc     (res),
      .clmul   (m_clmul),
      .acc_nxt (acc_nxt)
   );

   // Next state and gated response outputs; flush overrides every transition.
   always_comb begin
      state_nxt = state;
      accept    = 1'b0;
      req_ready = 1'b0;
      rsp_valid = 1'b0;
      rsp_hi    = 1'b0;
      rsp_wdata = '0;
      case (state)
         IDLE: begin
            req_ready = 1'b1;
            if (req_valid && !flush) begin
               accept    = 1'b1;
               state_nxt = is_iter ? MUL : RSP_LO;
            end
         end
         MUL: begin
            if (cnt == CNT_LAST) state_nxt = RSP_LO;
         end
         RSP_LO: begin
            rsp_valid = 1'b1;
            rsp_wdata = res[XLEN-1:0];
            if (rsp_ready) state_nxt = RSP_HI;
         end
         RSP_HI: begin
            rsp_valid = 1'b1;
            rsp_hi    = 1'b1;
            rsp_wdata = res[2*XLEN-1:XLEN];
            if (rsp_ready) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
      if (flush) state_nxt = IDLE;
   end

   // State register.
   always_ff @(posedge g_clk) begin
      if (!g_resetn) state <= IDLE;
      else           state <= state_nxt;
   end

   // Result/accumulator, digit counter and latched multiplier operands; rs2 shifts down one digit per step.
   always_ff @(posedge g_clk) begin
      if (!g_resetn) begin
         res     <= '0;
         cnt     <= '0;
         m_rs1   <= '0;
         m_rs2   <= '0;
         m_clmul <= 1'b0;
      end else if (accept) begin
         res     <= sc_res;
         cnt     <= '0;
         m_rs1   <= req_rs1;
         m_rs2   <= req_rs2;
         m_clmul <= is_clmul;
      end else if (state == MUL && !flush) begin
         res     <= acc_nxt;
         cnt     <= cnt + CW'(1);
         m_rs2   <= m_rs2 >> MUL_STEP;
      end
   end

endmodule

// File: tb/tb_scarv_cop_malu_iter.sv
// Directed bench for the iterative multi-precision ALU (32-bit and 64-bit instances).
// Latency: checks first-beat latency for single-cycle and iterative ops.
// Backpressure: exercises held beats, flush and reset mid-operation.
module tb_scarv_cop_malu_iter;

   logic        g_clk;
   logic        g_resetn;
   logic        flush;
   logic        req_valid;
   logic        req_ready;
   logic [2:0]  req_op;
   logic [31:0] req_rs1, req_rs2, req_rs3;
   logic        rsp_valid;
   logic        rsp_ready;
   logic        rsp_hi;
   logic [31:0] rsp_wdata;

   logic        w_flush;
   logic        w_req_valid;
   logic        w_req_ready;
   logic [2:0]  w_req_op;
   logic [63:0] w_req_rs1, w_req_rs2, w_req_rs3;
   logic        w_rsp_valid;
   logic        w_rsp_ready;
   logic        w_rsp_hi;
   logic [63:0] w_rsp_wdata;

   int checks = 0;
   int errors = 0;

   scarv_cop_malu_iter #(.XLEN(32), .MUL_STEP(4)) dut (
      .g_clk(g_clk), .g_resetn(g_resetn), .flush(flush),
      .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
      .req_rs1(req_rs1), .req_rs2(req_rs2), .req_rs3(req_rs3),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_hi(rsp_hi),
      .rsp_wdata(rsp_wdata)
   );

   scarv_cop_malu_iter #(.XLEN(64), .MUL_STEP(8)) dut64 (
      .g_clk(g_clk), .g_resetn(g_resetn), .flush(w_flush),
      .req_valid(w_req_valid), .req_ready(w_req_ready), .req_op(w_req_op),
      .req_rs1(w_req_rs1), .req_rs2(w_req_rs2), .req_rs3(w_req_rs3),
      .rsp_valid(w_rsp_valid), .rsp_ready(w_rsp_ready), .rsp_hi(w_rsp_hi),
      .rsp_wdata(w_rsp_wdata)
   );

   initial g_clk = 1'b0;
   always #5 g_clk = ~g_clk;

   task automatic tick();
      @(posedge g_clk);
      #1;
   endtask

   // Issue one request on the 32-bit unit, collect both beats with no backpressure.
   task automatic do_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] c, output int lat, output logic [31:0] lo,
                        output logic [31:0] hi, output logic lo_flag, output logic hi_flag,
                        output logic rdy_after);
      req_op = op; req_rs1 = a; req_rs2 = b; req_rs3 = c; req_valid = 1'b1;
      tick();
      req_valid = 1'b0; req_rs1 = '1; req_rs2 = '1; req_rs3 = '1;
      lat = 1;
      while (!rsp_valid && lat < 40) begin tick(); lat++; end
      lo = rsp_wdata; lo_flag = rsp_hi;
      rsp_ready = 1'b1;
      tick();
      hi = rsp_wdata; hi_flag = rsp_hi;
      tick();
      rsp_ready = 1'b0;
      rdy_after = req_ready;
   endtask

   task automatic do_op64(input logic [2:0] op, input logic [63:0] a, input logic [63:0] b,
                          input logic [63:0] c, output int lat, output logic [63:0] lo,
                          output logic [63:0] hi, output logic hi_flag);
      w_req_op = op; w_req_rs1 = a; w_req_rs2 = b; w_req_rs3 = c; w_req_valid = 1'b1;
      tick();
      w_req_valid = 1'b0;
      lat = 1;
      while (!w_rsp_valid && lat < 40) begin tick(); lat++; end
      lo = w_rsp_wdata;
      w_rsp_ready = 1'b1;
      tick();
      hi = w_rsp_wdata; hi_flag = w_rsp_hi;
      tick();
      w_rsp_ready = 1'b0;
   endtask

   task automatic test_reset();
      g_resetn = 1'b0;
      repeat (3) tick();
      g_resetn = 1'b1;
      checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_req_ready got=%0b exp=1", req_ready); end
      checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid got=%0b exp=0", rsp_valid); end
      checks++; if (rsp_hi !== 1'b0) begin errors++; $display("FAIL reset_rsp_hi got=%0b exp=0", rsp_hi); end
      checks++; if (rsp_wdata !== 32'h0) begin errors++; $display("FAIL reset_rsp_wdata got=%h exp=0", rsp_wdata); end
      checks++; if (w_req_ready !== 1'b1 || w_rsp_valid !== 1'b0 || w_rsp_wdata !== 64'h0)
         begin errors++; $display("FAIL reset_wide got rdy=%0b vld=%0b dat=%h exp 1/0/0", w_req_ready, w_rsp_valid, w_rsp_wdata); end
   endtask

   task automatic test_mul();
      int lat; logic [31:0] lo, hi; logic lf, hf, ra;
      do_op(3'd2, 32'hffffffff, 32'hffffffff, 32'hffffffff, lat, lo, hi, lf, hf, ra);
      checks++; if (lat !== 9) begin errors++; $display("FAIL mul_latency got=%0d exp=9", lat); end
      checks++; if (lo !== 32'h0) begin errors++; $display("FAIL mul_lo got=%h exp=00000000", lo); end
      checks++; if (hi !== 32'hffffffff) begin errors++; $display("FAIL mul_hi got=%h exp=ffffffff", hi); end
      checks++; if (lf !== 1'b0 || hf !== 1'b1) begin errors++; $display("FAIL mul_beat_order got lo_hi=%0b hi_hi=%0b exp 0/1", lf, hf); end
      do_op(3'd2, 32'h00012345, 32'h00000100, 32'h00000007, lat, lo, hi, lf, hf, ra);
      checks++; if (lo !== 32'h01234507 || hi !== 32'h0) begin errors++; $display("FAIL mul_small got=%h_%h exp=00000000_01234507", hi, lo); end
   endtask

   task automatic test_add_sub();
      int lat; logic [31:0] lo, hi; logic lf, hf, ra;
      do_op(3'd0, 32'hffffffff, 32'h00000001, 32'h00000001, lat, lo, hi, lf, hf, ra);
      checks++; if (lat !== 1) begin errors++; $display("FAIL add_latency got=%0d exp=1", lat); end
      checks++; if (lo !== 32'h1 || hi !== 32'h1) begin errors++; $display("FAIL add got=%h_%h exp=00000001_00000001", hi, lo); end
      checks++; if (ra !== 1'b1) begin errors++; $display("FAIL add_ready_after got=%0b exp=1", ra); end
      do_op(3'd1, 32'h0, 32'h1, 32'h0, lat, lo, hi, lf, hf, ra);
      checks++; if (lo !== 32'hffffffff || hi !== 32'hffffffff) begin errors++; $display("FAIL sub_borrow got=%h_%h exp=ffffffff_ffffffff", hi, lo); end
      do_op(3'd1, 32'h10, 32'h3, 32'h1, lat, lo, hi, lf, hf, ra);
      checks++; if (lo !== 32'hc || hi !== 32'h0) begin errors++; $display("FAIL sub_cin got=%h_%h exp=00000000_0000000c", hi, lo); end
   endtask

   task automatic test_clmul_macc();
      int lat; logic [31:0] lo, hi; logic lf, hf, ra;
      do_op(3'd3, 32'h3, 32'h3, 32'h0, lat, lo, hi, lf, hf, ra);
      checks++; if (lat !== 9) begin errors++; $display("FAIL clmul_latency got=%0d exp=9", lat); end
      checks++; if (lo !== 32'h5 || hi !== 32'h0) begin errors++; $display("FAIL clmul got=%h_%h exp=00000000_00000005", hi, lo); end
      do_op(3'd3, 32'h80000000, 32'h80000001, 32'h1, lat, lo, hi, lf, hf, ra);
      checks++; if (lo !== 32'h80000001 || hi !== 32'h40000000) begin errors++; $display("FAIL clmul_top got=%h_%h exp=40000000_80000001", hi, lo); end
      do_op(3'd4, 32'h1, 32'h0, 32'hffffffff, lat, lo, hi, lf, hf, ra);
      checks++; if (lo !== 32'h0 || hi !== 32'h1) begin errors++; $display("FAIL macc got=%h_%h exp=00000001_00000000", hi, lo); end
   endtask

   task automatic test_shift();
      int lat; logic [31:0] lo, hi; logic lf, hf, ra;
      do_op(3'd6, 32'h0, 32'h1, 32'h1, lat, lo, hi, lf, hf, ra);
      checks++; if (lo !== 32'h80000000 || hi !== 32'h0) begin errors++; $display("FAIL srl got=%h_%h exp=00000000_80000000", hi, lo); end
      do_op(3'd5, 32'h1, 32'h1, 32'h40, lat, lo, hi, lf, hf, ra);
      checks++; if (lo !== 32'h0 || hi !== 32'h0) begin errors++; $display("FAIL sll_ovf got=%h_%h exp=00000000_00000000", hi, lo); end
      do_op(3'd5, 32'h1, 32'h0, 32'h3f, lat, lo, hi, lf, hf, ra);
      checks++; if (lo !== 32'h0 || hi !== 32'h80000000) begin errors++; $display("FAIL sll_63 got=%h_%h exp=80000000_00000000", hi, lo); end
      do_op(3'd7, 32'h1234, 32'h5678, 32'h9, lat, lo, hi, lf, hf, ra);
      checks++; if (lat !== 1 || lo !== 32'h0 || hi !== 32'h0) begin errors++; $display("FAIL rsv got lat=%0d %h_%h exp lat=1 0_0", lat, hi, lo); end
   endtask

   task automatic test_backpressure();
      int lat; logic bad_hold; logic bad_rdy;
      req_op = 3'd0; req_rs1 = 32'h12345678; req_rs2 = 32'h11111111; req_rs3 = 32'h0; req_valid = 1'b1;
      tick();
      req_valid = 1'b0;
      lat = 1;
      while (!rsp_valid && lat < 40) begin tick(); lat++; end
      bad_hold = 1'b0; bad_rdy = 1'b0;
      repeat (5) begin
         if (rsp_valid !== 1'b1 || rsp_hi !== 1'b0 || rsp_wdata !== 32'h23456789) bad_hold = 1'b1;
         if (req_ready !== 1'b0) bad_rdy = 1'b1;
         req_valid = 1'b1;
         tick();
      end
      req_valid = 1'b0;
      checks++; if (bad_hold !== 1'b0) begin errors++; $display("FAIL bp_hold got vld=%0b hi=%0b dat=%h exp 1/0/23456789", rsp_valid, rsp_hi, rsp_wdata); end
      checks++; if (bad_rdy !== 1'b0) begin errors++; $display("FAIL bp_req_ready got=1 exp=0"); end
      checks++; if (rsp_wdata !== 32'h23456789 || rsp_hi !== 1'b0) begin errors++; $display("FAIL bp_lo got=%h hi=%0b exp=23456789 hi=0", rsp_wdata, rsp_hi); end
      rsp_ready = 1'b1;
      tick();
      checks++; if (rsp_valid !== 1'b1 || rsp_hi !== 1'b1 || rsp_wdata !== 32'h0) begin errors++; $display("FAIL bp_hi got vld=%0b hi=%0b dat=%h exp 1/1/0", rsp_valid, rsp_hi, rsp_wdata); end
      tick();
      rsp_ready = 1'b0;
      checks++; if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin errors++; $display("FAIL bp_done got rdy=%0b vld=%0b exp 1/0", req_ready, rsp_valid); end
   endtask

   task automatic test_flush();
      int lat; logic [31:0] lo, hi; logic lf, hf, ra; logic seen;
      req_op = 3'd2; req_rs1 = 32'hffffffff; req_rs2 = 32'hffffffff; req_rs3 = 32'hffffffff; req_valid = 1'b1;
      tick();
      req_valid = 1'b0;
      tick(); tick();
      flush = 1'b1;
      tick();
      flush = 1'b0;
      checks++; if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin errors++; $display("FAIL flush_idle got rdy=%0b vld=%0b exp 1/0", req_ready, rsp_valid); end
      seen = 1'b0;
      repeat (12) begin if (rsp_valid !== 1'b0) seen = 1'b1; tick(); end
      checks++; if (seen !== 1'b0) begin errors++; $display("FAIL flush_no_beat got=1 exp=0"); end
      do_op(3'd0, 32'h5, 32'h7, 32'h1, lat, lo, hi, lf, hf, ra);
      checks++; if (lat !== 1 || lo !== 32'hd || hi !== 32'h0) begin errors++; $display("FAIL flush_then_add got lat=%0d %h_%h exp lat=1 0_d", lat, hi, lo); end
      req_op = 3'd0; req_rs1 = 32'h1; req_rs2 = 32'h1; req_rs3 = 32'h0; req_valid = 1'b1; flush = 1'b1;
      tick();
      req_valid = 1'b0; flush = 1'b0;
      checks++; if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin errors++; $display("FAIL flush_blocks_accept got rdy=%0b vld=%0b exp 1/0", req_ready, rsp_valid); end
   endtask

   task automatic test_reset_mid_mul();
      int lat; logic [31:0] lo, hi; logic lf, hf, ra; logic seen;
      req_op = 3'd3; req_rs1 = 32'hdeadbeef; req_rs2 = 32'hcafef00d; req_rs3 = 32'h1; req_valid = 1'b1;
      tick();
      req_valid = 1'b0;
      tick(); tick();
      g_resetn = 1'b0;
      tick();
      g_resetn = 1'b1;
      checks++; if (req_ready !== 1'b1 || rsp_valid !== 1'b0 || rsp_wdata !== 32'h0) begin errors++; $display("FAIL rst_mid got rdy=%0b vld=%0b dat=%h exp 1/0/0", req_ready, rsp_valid, rsp_wdata); end
      seen = 1'b0;
      repeat (12) begin if (rsp_valid !== 1'b0) seen = 1'b1; tick(); end
      checks++; if (seen !== 1'b0) begin errors++; $display("FAIL rst_no_beat got=1 exp=0"); end
      do_op(3'd0, 32'hffffffff, 32'hffffffff, 32'h1, lat, lo, hi, lf, hf, ra);
      checks++; if (lo !== 32'hffffffff || hi !== 32'h1) begin errors++; $display("FAIL rst_then_add got=%h_%h exp=00000001_ffffffff", hi, lo); end
   endtask

   task automatic test_wide();
      int lat; logic [63:0] lo, hi; logic hf;
      do_op64(3'd2, 64'hffffffffffffffff, 64'hffffffffffffffff, 64'hffffffffffffffff, lat, lo, hi, hf);
      checks++; if (lat !== 9) begin errors++; $display("FAIL wide_latency got=%0d exp=9", lat); end
      checks++; if (lo !== 64'h0 || hi !== 64'hffffffffffffffff || hf !== 1'b1)
         begin errors++; $display("FAIL wide_mul got=%h_%h hi_flag=%0b exp=ffffffffffffffff_0000000000000000 1", hi, lo, hf); end
      do_op64(3'd6, 64'h0, 64'h1, 64'h1, lat, lo, hi, hf);
      checks++; if (lo !== 64'h8000000000000000 || hi !== 64'h0) begin errors++; $display("FAIL wide_srl got=%h_%h exp=0_8000000000000000", hi, lo); end
   endtask

   initial begin
      g_resetn = 1'b0; flush = 1'b0; req_valid = 1'b0; rsp_ready = 1'b0;
      req_op = 3'd0; req_rs1 = '0; req_rs2 = '0; req_rs3 = '0;
      w_flush = 1'b0; w_req_valid = 1'b0; w_rsp_ready = 1'b0;
      w_req_op = 3'd0; w_req_rs1 = '0; w_req_rs2 = '0; w_req_rs3 = '0;
      #1;
      test_reset();
      test_mul();
      test_add_sub();
      test_clmul_macc();
      test_shift();
      test_backpressure();
      test_flush();
      test_reset_mid_mul();
      test_wide();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/scarv_cop_malu_iter.md
Name: scarv_cop_malu_iter

Overview:
Parametrised, iterative successor to the coprocessor multi-precision ALU. Width is XLEN; the multiplier is a radix-2^MUL_STEP sequential unit instead of a single-cycle array. Requests use a valid/ready handshake. Every result is 2*XLEN bits and is returned as two response beats, low word then high word, so the CPR writeback port can sequence rd and rd+1. The block sits between the coprocessor decode stage and the CPR writeback mux.

Parameters:
XLEN, 32, limb width in bits; legal values 32 and 64.
MUL_STEP, 4, multiplier bits consumed per cycle; must divide XLEN; power of 2 in the range 1..XLEN.
SHW, $clog2(2*XLEN), width of the shift-amount field.

Ports:
g_clk  in  1  global clock
g_resetn  in  1  synchronous reset, active low
flush  in  1  abort the in-flight operation
req_valid  in  1  request present
req_ready  out  1  block idle; request accepted when req_valid && req_ready
req_op  in  3  operation code (shared package)
req_rs1  in  XLEN  operand 1
req_rs2  in  XLEN  operand 2
req_rs3  in  XLEN  operand 3 (carry-in, addend or shift amount)
rsp_valid  out  1  response beat valid
rsp_ready  in  1  consumer accepts the beat
rsp_hi  out  1  0 = low-word beat, 1 = high-word beat
rsp_wdata  out  XLEN  beat data

Behaviour:
- Reset: g_resetn, synchronous, active-low; clock g_clk. Reset forces state IDLE.
  - After reset: req_ready=1, rsp_valid=0, rsp_hi=0, rsp_wdata=0.
  - Result, counter and multiplier registers are cleared to 0.
- States: IDLE, MUL, RSP_LO, RSP_HI.
- req_ready = (state==IDLE). Operands and op are latched on accept; the inputs are don't-care afterwards.
- Operations; R is the 2*XLEN-bit result, all arithmetic is modulo 2^(2*XLEN):
  - ADD: R = rs1 + rs2 + rs3[0]
  - SUB: R = rs1 - rs2 - rs3[0]. Operands are zero-extended, so a borrow gives all-ones in the high word.
  - MUL: R = rs1*rs2 + rs3 (unsigned)
  - CLMUL: R = clmul(rs1,rs2) ^ zext(rs3)
  - MACC: R = {rs2,rs3} + rs1
  - SLL: R = {rs2,rs1} << rs3[SHW-1:0]
  - SRL: R = {rs2,rs1} >> rs3[SHW-1:0]
  - Shifts give R=0 if any bit of rs3[XLEN-1:SHW] is set.
  - Op 7 (reserved): R = 0, single-cycle path.
- Single-cycle ops (ADD/SUB/MACC/SLL/SRL/reserved):
  - Accept in cycle t; R registers at the t edge; state goes IDLE->RSP_LO.
  - rsp_valid is first high in cycle t+1.
- MUL/CLMUL:
  - Accept in cycle t: IDLE->MUL, acc=zext(rs3), cnt=0.
  - Each MUL cycle, with d = rs2 digit cnt (MUL_STEP bits):
    - MUL: acc += (rs1*d) << (cnt*MUL_STEP)
    - CLMUL: acc ^= clmul(rs1,d) << (cnt*MUL_STEP)
    - then cnt++.
  - After N = XLEN/MUL_STEP cycles: MUL->RSP_LO. rsp_valid is first high in cycle t+1+N.
  - The counter wraps only via the state change; there is no carry out of 2*XLEN.
- RSP_LO: rsp_valid=1, rsp_hi=0, rsp_wdata=R[XLEN-1:0]; moves to RSP_HI on rsp_ready.
- RSP_HI: rsp_valid=1, rsp_hi=1, rsp_wdata=R[2*XLEN-1:XLEN]; moves to IDLE on rsp_ready.
- Back-to-back: a new request is accepted no earlier than the cycle after the RSP_HI handshake (no bypass).
- Backpressure: while rsp_valid && !rsp_ready, rsp_wdata and rsp_hi are held stable.
- Outside RSP states: rsp_valid=0 and rsp_wdata=0 (gated, no stale data).
- flush:
  - Any state goes to IDLE at the next edge; all partial results are discarded and no further beats are issued.
  - Flush has priority over handshakes in the same cycle.
  - Flush in IDLE with req_valid: the request is not accepted.
- Reset mid-operation: behaves as flush and also clears all registers.

Decomposition:
- Package scarv_cop_malu_pkg:
  - op codes MALU_OP_ADD=0, SUB=1, MUL=2, CLMUL=3, MACC=4, SLL=5, SRL=6, RSV=7
  - state encoding IDLE/MUL/RSP_LO/RSP_HI
- One sub-module, scarv_cop_mul_step. It is combinational and handles one digit step:
  - inputs: rs1, digit, cnt, acc, clmul mode
  - output: next acc
- The FSM, single-cycle datapath and response mux stay in the top module.

Test Plan:
XLEN=32, MUL_STEP=4 unless noted.
1. MUL: rs1=ffffffff, rs2=ffffffff, rs3=ffffffff -> beats lo=00000000, hi=ffffffff. First rsp_valid is 9 cycles after accept.
2. ADD: rs1=ffffffff, rs2=00000001, rs3=00000001 -> lo=00000001, hi=00000001, rsp_valid 1 cycle after accept. SUB: rs1=0, rs2=1, rs3=0 -> lo=ffffffff, hi=ffffffff.
3. CLMUL: rs1=3, rs2=3, rs3=0 -> lo=00000005, hi=0. MACC: rs1=1, rs2=0, rs3=ffffffff -> lo=0, hi=1.
4. SRL: rs2=1, rs1=0, rs3=1 -> lo=80000000, hi=0. SLL with rs3=00000040 -> lo=0, hi=0.
5. Backpressure: rsp_ready=0 for 5 cycles in RSP_LO -> rsp_wdata and rsp_hi stable, req_ready=0. Then accept lo and hi in consecutive cycles; req_ready=1 the following cycle.
6. flush in the 3rd MUL cycle -> IDLE next cycle, no rsp_valid. An ADD issued right after returns correctly. Repeat with g_resetn=0 mid-MUL, and with XLEN=64, MUL_STEP=8 for the test 1 pattern extended to 64 bits.
